// File: rtl/sdr_sched_pkg.sv
// Shared types and constants for the SDRAM request scheduler.
// Covers FSM states, command classes and the column-bits decode helper.
package sdr_sched_pkg;

  localparam int unsigned APP_AW_D  = 26;
  localparam int unsigned ROW_W_D   = 13;
  localparam int unsigned COL_W_D   = 12;
  localparam int unsigned LEN_W_D   = 8;
  localparam int unsigned NUM_BANKS = 4;

  typedef enum logic [1:0] {
    IDLE,
    DECODE,
    ISSUE,
    RFSH
  } state_t;

  typedef enum logic [1:0] {
    RW         = 2'b00,
    ACT_RW     = 2'b01,
    PRE_ACT_RW = 2'b10
  } cmd_type_t;

  // Number of column address bits selected by cfg_colbits (8..11).
  function automatic logic [4:0] colbits_to_n(input logic [1:0] colbits);
    return 5'd8 + {3'b000, colbits};
  endfunction

endpackage

// File: rtl/sdr_bank_tracker.sv
// Open-row table for the four SDRAM banks.
// Classifies a lookup as hit, miss or conflict; supports row update and clear-all.
module sdr_bank_tracker
  import sdr_sched_pkg::*;
#(
  parameter int unsigned ROW_W = ROW_W_D
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [1:0]       lk_bank,
  input  logic [ROW_W-1:0] lk_row,
  output logic [1:0]       lk_type,
  input  logic             upd_we,
  input  logic [1:0]       upd_bank,
  input  logic [ROW_W-1:0] upd_row,
  output logic [3:0]       open_flags
);

  logic [ROW_W-1:0] rows [NUM_BANKS];
  cmd_type_t        lk_class;

  always_comb begin
    lk_class = ACT_RW;
    if (open_flags[lk_bank]) begin
      lk_class = (rows[lk_bank] == lk_row) ? RW : PRE_ACT_RW;
    end
  end

  assign lk_type = lk_class;

  // Refresh closes every bank but leaves stored rows untouched; they are
  // only meaningful while the matching open flag is set.
  always_ff @(posedge clk) begin
    if (rst) begin
      open_flags <= '0;
      for (int unsigned i = 0; i < NUM_BANKS; i++) begin
        rows[i] <= '0;
      end
    end else if (clr) begin
      open_flags <= '0;
    end else if (upd_we) begin
      open_flags[upd_bank] <= 1'b1;
      rows[upd_bank]       <= upd_row;
    end
  end

endmodule

// File: rtl/sdr_req_sched.sv
// Two-requester round-robin scheduler in front of the SDRAM command generator.
// Decodes bank/row/column, classifies against open rows and issues one descriptor per request.
module sdr_req_sched
  import sdr_sched_pkg::*;
#(
  parameter int unsigned APP_AW = APP_AW_D,
  parameter int unsigned ROW_W  = ROW_W_D,
  parameter int unsigned COL_W  = COL_W_D,
  parameter int unsigned LEN_W  = LEN_W_D
) (
  input  logic              sdram_clk,
  input  logic              sdram_rst,
  input  logic [1:0]        cfg_colbits,
  input  logic [1:0]        req_valid,
  input  logic [APP_AW-1:0] req_addr0,
  input  logic [APP_AW-1:0] req_addr1,
  input  logic [1:0]        req_wr,
  input  logic [LEN_W-1:0]  req_len0,
  input  logic [LEN_W-1:0]  req_len1,
  output logic [1:0]        req_ack,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic [1:0]        cmd_type,
  output logic [1:0]        cmd_bank,
  output logic [ROW_W-1:0]  cmd_row,
  output logic [COL_W-1:0]  cmd_col,
  output logic              cmd_wr,
  output logic [LEN_W-1:0]  cmd_len,
  output logic              cmd_src,
  input  logic              rfsh_req,
  output logic              rfsh_gnt,
  output logic [3:0]        bank_open
);

  state_t            state;
  logic              rr_ptr;
  logic              gnt_id;

  logic [APP_AW-1:0] q_addr;
  logic              q_wr;
  logic [LEN_W-1:0]  q_len;
  logic              q_src;
  logic [1:0]        q_colbits;

  logic [4:0]        n;
  logic [COL_W-1:0]  col_mask;
  logic [1:0]        dec_bank;
  logic [ROW_W-1:0]  dec_row;
  logic [COL_W-1:0]  dec_col;
  logic [1:0]        lk_type;

  // With both requesting, the pointer names the requester not granted last.
  assign gnt_id = (req_valid == 2'b11) ? rr_ptr : req_valid[1];

  always_comb begin
    n        = colbits_to_n(q_colbits);
    col_mask = ~({COL_W{1'b1}} << n);
    dec_bank = q_addr[n +: 2];
    dec_row  = q_addr[(n + 5'd2) +: ROW_W];
    dec_col  = q_addr[COL_W-1:0] & col_mask;
  end

  sdr_bank_tracker #(
    .ROW_W(ROW_W)
  ) u_bank_tracker (
    .clk       (sdram_clk),
    .rst       (sdram_rst),
    .clr       (state == RFSH),
    .lk_bank   (dec_bank),
    .lk_row    (dec_row),
    .lk_type   (lk_type),
    .upd_we    ((state == ISSUE) && cmd_ready),
    .upd_bank  (cmd_bank),
    .upd_row   (cmd_row),
    .open_flags(bank_open)
  );

  always_ff @(posedge sdram_clk) begin
    if (sdram_rst) begin
      state     <= IDLE;
      rr_ptr    <= 1'b0;
      req_ack   <= '0;
      rfsh_gnt  <= 1'b0;
      cmd_valid <= 1'b0;
      cmd_type  <= '0;
      cmd_bank  <= '0;
      cmd_row   <= '0;
      cmd_col   <= '0;
      cmd_wr    <= 1'b0;
      cmd_len   <= '0;
      cmd_src   <= 1'b0;
      q_addr    <= '0;
      q_wr      <= 1'b0;
      q_len     <= '0;
      q_src     <= 1'b0;
      q_colbits <= '0;
    end else begin
      req_ack  <= '0;
      rfsh_gnt <= 1'b0;
      case (state)
        IDLE: begin
          if (rfsh_req) begin
            state <= RFSH;
          end else if (|req_valid) begin
            req_ack   <= gnt_id ? 2'b10 : 2'b01;
            q_addr    <= gnt_id ? req_addr1 : req_addr0;
            q_len     <= gnt_id ? req_len1 : req_len0;
            q_wr      <= req_wr[gnt_id];
            q_src     <= gnt_id;
            q_colbits <= cfg_colbits;
            rr_ptr    <= ~gnt_id;
            state     <= DECODE;
          end
        end
        DECODE: begin
          cmd_type  <= lk_type;
          cmd_bank  <= dec_bank;
          cmd_row   <= dec_row;
          cmd_col   <= dec_col;
          cmd_wr    <= q_wr;
          cmd_len   <= q_len;
          cmd_src   <= q_src;
          cmd_valid <= 1'b1;
          state     <= ISSUE;
        end
        ISSUE: begin
          if (cmd_ready) begin
            cmd_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        RFSH: begin
          rfsh_gnt <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdr_req_sched.sv
// Self-checking bench for sdr_req_sched: directed vector table, corner sequences,
// and randomized traffic against an arithmetic address/bank-table model.
module tb_sdr_req_sched;

  logic        sdram_clk = 1'b0;
  logic        sdram_rst;
  logic [1:0]  cfg_colbits;
  logic [1:0]  req_valid;
  logic [25:0] req_addr0, req_addr1;
  logic [1:0]  req_wr;
  logic [7:0]  req_len0, req_len1;
  logic [1:0]  req_ack;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_type;
  logic [1:0]  cmd_bank;
  logic [12:0] cmd_row;
  logic [11:0] cmd_col;
  logic        cmd_wr;
  logic [7:0]  cmd_len;
  logic        cmd_src;
  logic        rfsh_req;
  logic        rfsh_gnt;
  logic [3:0]  bank_open;

  sdr_req_sched #(
    .APP_AW(26), .ROW_W(13), .COL_W(12), .LEN_W(8)
  ) dut (
    .sdram_clk(sdram_clk), .sdram_rst(sdram_rst), .cfg_colbits(cfg_colbits),
    .req_valid(req_valid), .req_addr0(req_addr0), .req_addr1(req_addr1),
    .req_wr(req_wr), .req_len0(req_len0), .req_len1(req_len1), .req_ack(req_ack),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_type(cmd_type),
    .cmd_bank(cmd_bank), .cmd_row(cmd_row), .cmd_col(cmd_col), .cmd_wr(cmd_wr),
    .cmd_len(cmd_len), .cmd_src(cmd_src), .rfsh_req(rfsh_req), .rfsh_gnt(rfsh_gnt),
    .bank_open(bank_open)
  );

  always #5 sdram_clk = ~sdram_clk;

  typedef struct packed {
    logic [1:0]  typ;
    logic [1:0]  bank;
    logic [12:0] row;
    logic [11:0] col;
    logic        wr;
    logic [7:0]  len;
    logic        src;
  } desc_t;

  typedef struct {
    logic [1:0]  cfg;
    logic        src;
    logic [25:0] addr;
    logic        wr;
    logic [7:0]  len;
    logic [1:0]  typ;
    logic [1:0]  bank;
    logic [12:0] row;
    logic [11:0] col;
  } vec_t;

  int unsigned n_pass = 0;
  int unsigned n_tot  = 0;

  // Reference model: open flags, stored rows, round-robin preference.
  bit          m_open [4];
  int unsigned m_row  [4];
  bit          m_ptr;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic m_reset();
    for (int i = 0; i < 4; i++) begin
      m_open[i] = 0;
      m_row[i]  = 0;
    end
    m_ptr = 0;
  endtask

  function automatic logic [3:0] m_open_vec();
    logic [3:0] v;
    for (int i = 0; i < 4; i++) v[i] = m_open[i];
    return v;
  endfunction

  function automatic desc_t predict(input logic [25:0] addr, input logic [1:0] cfg,
                                    input logic wr, input logic [7:0] len, input logic src);
    longint unsigned a, n, bank, row, col;
    desc_t d;
    a    = addr;
    n    = 8 + cfg;
    col  = a % (64'd1 << n);
    bank = (a >> n) % 4;
    row  = (a >> (n + 2)) % 8192;
    if (!m_open[bank])                   d.typ = 2'b01;
    else if (m_row[bank] == row)         d.typ = 2'b00;
    else                                 d.typ = 2'b10;
    d.bank = bank[1:0];
    d.row  = row[12:0];
    d.col  = col[11:0];
    d.wr   = wr;
    d.len  = len;
    d.src  = src;
    return d;
  endfunction

  function automatic desc_t dut_desc();
    return {cmd_type, cmd_bank, cmd_row, cmd_col, cmd_wr, cmd_len, cmd_src};
  endfunction

  function automatic logic [25:0] mk_addr(input logic [1:0] cfg, input int unsigned bank,
                                          input int unsigned row, input int unsigned col,
                                          input int unsigned junk);
    longint unsigned n, a;
    n = 8 + cfg;
    a = (longint'(junk) << (n + 15)) | (longint'(row) << (n + 2)) |
        (longint'(bank) << n) | (longint'(col) % (64'd1 << n));
    return a[25:0];
  endfunction

  task automatic wait_ack(input logic [1:0] exp_ack);
    int lat = 0;
    bit got = 0;
    while (!got && lat < 20) begin
      @(negedge sdram_clk);
      lat++;
      if (req_ack != 2'b00) got = 1;
    end
    chk("ack_latency", 64'(lat), 64'd1);
    chk("ack_id", 64'(req_ack), 64'(exp_ack));
  endtask

  task automatic issue_phase(input desc_t e, input int dly);
    @(negedge sdram_clk);
    chk("cmd_valid", 64'(cmd_valid), 64'd1);
    chk("ack_pulse", 64'(req_ack), 64'd0);
    chk("desc", 64'(dut_desc()), 64'(e));
    for (int d = 0; d < dly; d++) begin
      @(negedge sdram_clk);
      chk("hold", 64'({rfsh_gnt, cmd_valid, dut_desc()}), 64'({1'b0, 1'b1, e}));
    end
    cmd_ready = 1'b1;
    @(negedge sdram_clk);
    cmd_ready = 1'b0;
    chk("cmd_drop", 64'(cmd_valid), 64'd0);
    m_open[e.bank] = 1;
    m_row[e.bank]  = e.row;
    chk("bank_open", 64'(bank_open), 64'(m_open_vec()));
  endtask

  task automatic txn(input logic [1:0] vmask, input bit hold, input int dly, input bit early);
    logic  g;
    desc_t e;
    g     = (vmask == 2'b11) ? m_ptr : vmask[1];
    m_ptr = ~g;
    e     = predict(g ? req_addr1 : req_addr0, cfg_colbits, req_wr[g],
                    g ? req_len1 : req_len0, g);
    req_valid = vmask;
    if (early) cmd_ready = 1'b1;
    wait_ack(g ? 2'b10 : 2'b01);
    if (!hold) req_valid = 2'b00;
    issue_phase(e, dly);
  endtask

  task automatic do_refresh();
    bit got = 0;
    rfsh_req = 1'b1;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge sdram_clk);
      if (rfsh_gnt) got = 1;
    end
    rfsh_req = 1'b0;
    chk("rfsh_gnt", 64'(got), 64'd1);
    chk("rfsh_clear", 64'(bank_open), 64'd0);
    for (int i = 0; i < 4; i++) m_open[i] = 0;
    @(negedge sdram_clk);
    chk("rfsh_pulse", 64'(rfsh_gnt), 64'd0);
  endtask

  vec_t vecs [8];

  initial begin
    vecs[0] = '{2'd0, 1'b0, 26'h000_0680, 1'b0, 8'd4,   2'b01, 2'd2, 13'h001,  12'h080};
    vecs[1] = '{2'd0, 1'b0, 26'h000_0680, 1'b0, 8'd4,   2'b00, 2'd2, 13'h001,  12'h080};
    vecs[2] = '{2'd3, 1'b1, 26'h000_2800, 1'b1, 8'd8,   2'b01, 2'd1, 13'h001,  12'h000};
    vecs[3] = '{2'd3, 1'b1, 26'h000_4800, 1'b1, 8'd8,   2'b10, 2'd1, 13'h002,  12'h000};
    vecs[4] = '{2'd0, 1'b0, 26'h000_0680, 1'b1, 8'd1,   2'b00, 2'd2, 13'h001,  12'h080};
    vecs[5] = '{2'd2, 1'b1, 26'h012_3456, 1'b0, 8'd255, 2'b10, 2'd1, 13'h123,  12'h056};
    vecs[6] = '{2'd1, 1'b0, 26'h3FF_FFFF, 1'b1, 8'd0,   2'b01, 2'd3, 13'h1FFF, 12'h1FF};
    vecs[7] = '{2'd1, 1'b1, 26'h0FF_FFFF, 1'b0, 8'd16,  2'b00, 2'd3, 13'h1FFF, 12'h1FF};

    sdram_rst   = 1'b1;
    cfg_colbits = 2'b00;
    req_valid   = 2'b00;
    req_addr0   = '0;
    req_addr1   = '0;
    req_wr      = 2'b00;
    req_len0    = '0;
    req_len1    = '0;
    cmd_ready   = 1'b0;
    rfsh_req    = 1'b0;
    m_reset();
    repeat (3) @(negedge sdram_clk);
    chk("reset_outputs",
        64'({req_ack, cmd_valid, cmd_type, cmd_bank, cmd_row, cmd_col, cmd_wr,
             cmd_len, cmd_src, rfsh_gnt, bank_open}), 64'd0);
    sdram_rst = 1'b0;
    @(negedge sdram_clk);

    // Directed address-mapping and classification vectors.
    for (int i = 0; i < 8; i++) begin
      desc_t e;
      cfg_colbits = vecs[i].cfg;
      if (vecs[i].src) begin
        req_addr1 = vecs[i].addr; req_len1 = vecs[i].len; req_wr[1] = vecs[i].wr;
      end else begin
        req_addr0 = vecs[i].addr; req_len0 = vecs[i].len; req_wr[0] = vecs[i].wr;
      end
      e = '{vecs[i].typ, vecs[i].bank, vecs[i].row, vecs[i].col,
            vecs[i].wr, vecs[i].len, vecs[i].src};
      m_ptr     = ~vecs[i].src;
      req_valid = vecs[i].src ? 2'b10 : 2'b01;
      wait_ack(req_valid);
      req_valid = 2'b00;
      issue_phase(e, i % 3);
    end

    // cfg_colbits changes during DECODE must not affect the in-flight request.
    begin
      desc_t e;
      cfg_colbits = 2'b01;
      req_addr0   = 26'h012_3456;
      req_wr[0]   = 1'b0;
      req_len0    = 8'd7;
      m_ptr       = 1'b1;
      req_valid   = 2'b01;
      wait_ack(2'b01);
      req_valid   = 2'b00;
      cfg_colbits = 2'b10;
      e = '{2'b00, 2'd2, 13'h246, 12'h056, 1'b0, 8'd7, 1'b0};
      e.typ = predict(26'h012_3456, 2'b01, 1'b0, 8'd7, 1'b0).typ;
      issue_phase(e, 1);
      e = '{2'b00, 2'd1, 13'h123, 12'h056, 1'b0, 8'd7, 1'b0};
      e.typ = predict(26'h012_3456, 2'b10, 1'b0, 8'd7, 1'b0).typ;
      m_ptr     = 1'b1;
      req_valid = 2'b01;
      wait_ack(2'b01);
      req_valid = 2'b00;
      issue_phase(e, 0);
    end

    // Randomized traffic with a small bank/row working set to provoke all classes.
    for (int it = 0; it < 40; it++) begin
      int dly;
      if ($urandom_range(0, 7) == 0) do_refresh();
      cfg_colbits = 2'($urandom_range(0, 3));
      req_addr0 = mk_addr(cfg_colbits, $urandom_range(0, 3), $urandom_range(0, 2),
                          $urandom, $urandom);
      req_addr1 = mk_addr(cfg_colbits, $urandom_range(0, 3), $urandom_range(0, 2),
                          $urandom, $urandom);
      req_wr    = 2'($urandom_range(0, 3));
      req_len0  = 8'($urandom);
      req_len1  = 8'($urandom);
      dly       = $urandom_range(0, 3);
      txn(2'($urandom_range(1, 3)), 1'b0, dly, (dly == 0) && ($urandom_range(0, 1) == 1));
    end

    // Refresh requested while a descriptor is stalled: held stable, refresh wins next.
    begin
      bit got = 0;
      desc_t e;
      cfg_colbits = 2'b00;
      req_addr0   = 26'h000_0680;
      req_wr      = 2'b00;
      req_len0    = 8'd4;
      m_ptr       = 1'b1;
      e           = predict(req_addr0, 2'b00, 1'b0, 8'd4, 1'b0);
      req_valid   = 2'b01;
      wait_ack(2'b01);
      rfsh_req    = 1'b1;
      req_addr1   = 26'h000_0680;
      req_len1    = 8'd2;
      req_valid   = 2'b10;
      issue_phase(e, 5);
      for (int i = 0; i < 10 && !got; i++) begin
        @(negedge sdram_clk);
        if (rfsh_gnt || req_ack != 2'b00) got = 1;
      end
      rfsh_req = 1'b0;
      chk("rfsh_before_ack", 64'({rfsh_gnt, req_ack}), 64'b100);
      chk("rfsh_closes_banks", 64'(bank_open), 64'd0);
      for (int i = 0; i < 4; i++) m_open[i] = 0;
      txn(2'b10, 1'b0, 0, 1'b0);
    end

    // Synchronous reset while ISSUE waits: descriptor dropped, table and pointer cleared.
    begin
      cfg_colbits = 2'b01;
      req_addr0   = 26'h000_1234;
      m_ptr       = 1'b1;
      req_valid   = 2'b01;
      wait_ack(2'b01);
      req_valid   = 2'b00;
      @(negedge sdram_clk);
      chk("pre_rst_valid", 64'(cmd_valid), 64'd1);
      chk("pre_rst_open", 64'(bank_open), 64'(m_open_vec()));
      sdram_rst = 1'b1;
      @(negedge sdram_clk);
      sdram_rst = 1'b0;
      chk("rst_mid_issue", 64'({cmd_valid, req_ack, bank_open}), 64'd0);
      m_reset();
    end

    // Both requesters held: grants alternate starting with requester 0 after reset.
    cfg_colbits = 2'b00;
    req_addr0   = 26'h000_0680;
    req_addr1   = 26'h000_0F00;
    req_wr      = 2'b10;
    req_len0    = 8'd3;
    req_len1    = 8'd9;
    for (int k = 0; k < 6; k++) txn(2'b11, 1'b1, k % 2, 1'b0);
    req_valid = 2'b00;
    repeat (2) @(negedge sdram_clk);
    chk("idle_no_ack", 64'({req_ack, cmd_valid}), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
